// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } fetchState_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : Single-outstanding instruction fetch FSM with branch redirect.
//               Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects are
//               ignored and reported on misalignTrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        takeBranch,
    input  logic [31:0] branchAddress,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        fetchValid,
    input  logic        fetchReady,
    output logic [31:0] fetchInstr,
    output logic [31:0] fetchPc,
    output logic        misalignTrap
);

    fetchState_t state_q;
    fetchState_t state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] req_pc_q;
    logic [31:0] instr_buf_q;
    logic [31:0] fetch_pc_q;
    logic        req_pc_load;
    logic        buf_load;
    logic        redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q;

    // A misaligned target is not a redirect at all; it only raises the trap.
    assign misaligned   = (branchAddress[1:0] != 2'b00);
    assign redirect     = takeBranch && !misaligned;
    assign misalignTrap = trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= takeBranch && misaligned;
        end
    end
`else
    assign redirect     = takeBranch;
    assign misalignTrap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_load  = 1'b0;
        buf_load     = 1'b0;
        imemReqValid = 1'b0;
        fetchValid   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    pc_d = branchAddress;
                end
            end
            REQ: begin
                imemReqValid = 1'b1;
                if (redirect) begin
                    pc_d = branchAddress;
                    // An accepted request in the redirect cycle is stale.
                    state_d = imemReqReady ? DISCARD : REQ;
                end else if (imemReqReady) begin
                    req_pc_load = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = branchAddress;
                    state_d = imemRespValid ? REQ : DISCARD;
                end else if (imemRespValid) begin
                    buf_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                fetchValid = !redirect;
                if (redirect) begin
                    pc_d    = branchAddress;
                    state_d = REQ;
                end else if (fetchReady) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = REQ;
                end
            end
            DISCARD: begin
                // Leaving on the stale response even if a new redirect lands
                // with it; otherwise we would wait for a response never issued.
                if (redirect) begin
                    pc_d = branchAddress;
                end
                if (imemRespValid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'd0;
            instr_buf_q <= 32'd0;
            fetch_pc_q  <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (req_pc_load) begin
                req_pc_q <= pc_q;
            end
            if (buf_load) begin
                instr_buf_q <= imemRespData;
                fetch_pc_q  <= req_pc_q;
            end
        end
    end

    assign imemReqAddr = pc_q;
    assign fetchInstr  = instr_buf_q;
    assign fetchPc     = fetch_pc_q;

endmodule : fetch_controller

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module      : tb_fetch_controller
// Description : Directed table-driven bench for fetch_controller (default
//               RESET_PC), with hand sequences for misalign, wrap and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        takeBranch;
    logic [31:0] branchAddress;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fetchInstr;
    logic [31:0] fetchPc;
    logic        misalignTrap;

    int checks = 0;
    int errors = 0;

    fetch_controller dut (
        .clk           (clk),
        .reset         (reset),
        .takeBranch    (takeBranch),
        .branchAddress (branchAddress),
        .imemReqValid  (imemReqValid),
        .imemReqReady  (imemReqReady),
        .imemReqAddr   (imemReqAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .fetchValid    (fetchValid),
        .fetchReady    (fetchReady),
        .fetchInstr    (fetchInstr),
        .fetchPc       (fetchPc),
        .misalignTrap  (misalignTrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tb;
        logic [31:0] ba;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        fr;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_fpc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] IA0 = 32'h1111_0000;
    localparam logic [31:0] IA4 = 32'h1111_0004;
    localparam logic [31:0] IA8 = 32'h1111_0008;
    localparam logic [31:0] IB0 = 32'h2222_0100;
    localparam logic [31:0] IC4 = 32'h3333_0104;

    task automatic add(input logic tb, input logic [31:0] ba, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic fr,
                       input logic e_rqv, input logic [31:0] e_addr, input logic e_fv,
                       input logic [31:0] e_fpc, input logic [31:0] e_instr);
        vec_t v;
        v = '{tb, ba, rdy, rv, rd, fr, e_rqv, e_addr, e_fv, e_fpc, e_instr};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic tb, input logic [31:0] ba, input logic rdy,
                         input logic rv, input logic [31:0] rd, input logic fr);
        takeBranch    = tb;
        branchAddress = ba;
        imemReqReady  = rdy;
        imemRespValid = rv;
        imemRespData  = rd;
        fetchReady    = fr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Rows: inputs (tb, ba, rdy, rv, rd, fr) | expected (reqValid, reqAddr, fetchValid, fetchPc, fetchInstr)
        add(0, 32'h0,   1, 0, 32'h0,       1,   0, 32'h0,   0, 32'h0,   32'h0);  // IDLE
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'h0,   0, 32'h0,   32'h0);  // REQ 0
        add(0, 32'h0,   1, 1, IA0,         1,   0, 32'h0,   0, 32'h0,   32'h0);  // WAIT
        add(0, 32'h0,   1, 0, 32'h0,       1,   0, 32'h0,   1, 32'h0,   IA0);    // HOLD
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'h4,   0, 32'h0,   IA0);
        add(0, 32'h0,   1, 1, IA4,         1,   0, 32'h4,   0, 32'h0,   IA0);
        add(0, 32'h0,   1, 0, 32'h0,       1,   0, 32'h4,   1, 32'h4,   IA4);
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'h8,   0, 32'h4,   IA4);
        add(0, 32'h0,   1, 1, IA8,         1,   0, 32'h8,   0, 32'h4,   IA4);
        add(0, 32'h0,   1, 0, 32'h0,       1,   0, 32'h8,   1, 32'h8,   IA8);
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'hC,   0, 32'h8,   IA8);    // REQ C
        add(1, 32'h100, 1, 0, 32'h0,       1,   0, 32'hC,   0, 32'h8,   IA8);    // branch in WAIT
        add(0, 32'h0,   1, 0, 32'h0,       1,   0, 32'h100, 0, 32'h8,   IA8);    // DISCARD
        add(0, 32'h0,   1, 1, 32'hDEAD,    1,   0, 32'h100, 0, 32'h8,   IA8);    // stale response
        add(0, 32'h0,   0, 0, 32'h0,       1,   1, 32'h100, 0, 32'h8,   IA8);
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'h100, 0, 32'h8,   IA8);
        add(0, 32'h0,   1, 1, IB0,         1,   0, 32'h100, 0, 32'h8,   IA8);
        for (int i = 0; i < 5; i++)
            add(0, 32'h0, 1, 0, 32'h0,     0,   0, 32'h100, 1, 32'h100, IB0);    // HOLD stall
        add(0, 32'h0,   1, 0, 32'h0,       1,   0, 32'h100, 1, 32'h100, IB0);
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'h104, 0, 32'h100, IB0);
        add(0, 32'h0,   1, 1, IC4,         1,   0, 32'h104, 0, 32'h100, IB0);
        add(1, 32'h200, 1, 0, 32'h0,       1,   0, 32'h104, 0, 32'h104, IC4);    // branch in HOLD
        add(0, 32'h0,   0, 0, 32'h0,       1,   1, 32'h200, 0, 32'h104, IC4);
        add(1, 32'h300, 1, 0, 32'h0,       1,   1, 32'h200, 0, 32'h104, IC4);    // branch in REQ+ready
        add(0, 32'h0,   1, 1, 32'hEEEE,    1,   0, 32'h300, 0, 32'h104, IC4);
        add(0, 32'h0,   1, 0, 32'h0,       1,   1, 32'h300, 0, 32'h104, IC4);
        add(1, 32'h180, 1, 1, 32'hF,       1,   0, 32'h300, 0, 32'h104, IC4);    // branch + resp in WAIT
        add(0, 32'h0,   0, 0, 32'h0,       1,   1, 32'h180, 0, 32'h104, IC4);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reqValid", {31'd0, imemReqValid}, 32'd0);
        chk("rst_reqAddr", imemReqAddr, 32'h0);
        chk("rst_fetchValid", {31'd0, fetchValid}, 32'd0);
        chk("rst_fetchPc", fetchPc, 32'd0);
        chk("rst_fetchInstr", fetchInstr, 32'd0);
        chk("rst_trap", {31'd0, misalignTrap}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].tb, vecs[i].ba, vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].fr);
            @(negedge clk);
            chk($sformatf("v%0d_reqValid", i), {31'd0, imemReqValid}, {31'd0, vecs[i].e_rqv});
            chk($sformatf("v%0d_reqAddr", i), imemReqAddr, vecs[i].e_addr);
            chk($sformatf("v%0d_fetchValid", i), {31'd0, fetchValid}, {31'd0, vecs[i].e_fv});
            chk($sformatf("v%0d_fetchPc", i), fetchPc, vecs[i].e_fpc);
            chk($sformatf("v%0d_fetchInstr", i), fetchInstr, vecs[i].e_instr);
            chk($sformatf("v%0d_trap", i), {31'd0, misalignTrap}, 32'd0);
            next_cycle();
        end

        // Misaligned redirect while in REQ (pc = 0x180)
        drive(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("mis_trap_same_cycle", {31'd0, misalignTrap}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_addr", imemReqAddr, 32'h180);
        chk("mis_trap_pulse", {31'd0, misalignTrap}, 32'd1);
`else
        chk("mis_addr", imemReqAddr, 32'h102);
        chk("mis_trap_pulse", {31'd0, misalignTrap}, 32'd0);
`endif
        chk("mis_reqValid", {31'd0, imemReqValid}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("mis_trap_end", {31'd0, misalignTrap}, 32'd0);
        next_cycle();

        // PC wrap at top of address space
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wrap_reqAddr", imemReqAddr, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_4444, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("wrap_fetchValid", {31'd0, fetchValid}, 32'd1);
        chk("wrap_fetchPc", fetchPc, 32'hFFFF_FFFC);
        chk("wrap_fetchInstr", fetchInstr, 32'h4444_4444);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wrap_next_addr", imemReqAddr, 32'h0);
        chk("wrap_next_reqValid", {31'd0, imemReqValid}, 32'd1);

        // Reset asserted while holding an instruction
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("hold_fetchValid", {31'd0, fetchValid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rsthold_fetchValid", {31'd0, fetchValid}, 32'd0);
        chk("rsthold_fetchPc", fetchPc, 32'd0);
        chk("rsthold_reqValid", {31'd0, imemReqValid}, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rel_idle_reqValid", {31'd0, imemReqValid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rel_reqValid", {31'd0, imemReqValid}, 32'd1);
        chk("rel_reqAddr", imemReqAddr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_controller

`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 takeBranch  input  1  redirect request; valid any cycle.
REQ-005 branchAddress  input  32  redirect target; sampled only when takeBranch=1.
REQ-006 imemReqValid  output  1  instruction-memory request valid.
REQ-007 imemReqReady  input  1  memory accepts the request this cycle.
REQ-008 imemReqAddr  output  32  request address, equal to the internal PC.
REQ-009 imemRespValid  input  1  response data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
REQ-010 imemRespData  input  32  instruction word.
REQ-011 fetchValid  output  1  instruction offered to decode.
REQ-012 fetchReady  input  1  decode accepts the offered instruction.
REQ-013 fetchInstr  output  32  offered instruction.
REQ-014 fetchPc  output  32  address of the offered instruction.
REQ-015 misalignTrap  output  1  one-cycle pulse on a misaligned redirect; present in both builds.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, DISCARD; at most one memory request is outstanding.
REQ-017 IDLE: all handshake outputs 0; SHALL move to REQ on the first clock after reset deasserts.
REQ-018 REQ: imemReqValid=1; on imemReqReady, pc is latched as reqPc and the FSM SHALL move to WAIT.
REQ-019 WAIT: on imemRespValid, imemRespData is stored in instrBuf, reqPc in fetchPc, and the FSM SHALL move to HOLD; fetchValid rises the cycle after imemRespValid.
REQ-020 HOLD: fetchValid = 1 AND NOT takeBranch; on fetchValid&&fetchReady, pc <= pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) and the FSM SHALL move to REQ.
REQ-021 takeBranch SHALL override sequential increment in every state; pc <= branchAddress on that edge.
REQ-022 takeBranch in IDLE or REQ without imemReqReady: pc updated, next state REQ.
REQ-023 takeBranch in REQ with imemReqReady the same cycle: accepted request is stale; next state DISCARD.
REQ-024 takeBranch in WAIT: with imemRespValid the same cycle the response SHALL be dropped and next state is REQ; otherwise next state is DISCARD.
REQ-025 DISCARD: imemReqValid=0; the next imemRespValid is dropped without touching instrBuf and the FSM SHALL move to REQ; a further takeBranch here updates pc and stays in DISCARD.
REQ-026 takeBranch in HOLD: buffered instruction dropped, no fetch handshake occurs, next state REQ.
REQ-027 fetchInstr/fetchPc SHALL remain stable while fetchValid=1 and fetchReady=0.

Reset
REQ-028 While reset=1: state=IDLE, pc=RESET_PC, instrBuf=0, fetchPc=0, imemReqValid=0, fetchValid=0, misalignTrap=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it; a response arriving after reset releases while in IDLE/REQ SHALL NOT occur (memory is reset together).

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: takeBranch with branchAddress[1:0]!=0 SHALL NOT redirect, SHALL pulse misalignTrap (registered, next cycle) and leave pc and state unchanged.
REQ-031 Macro undefined: misalignTrap tied 0; branchAddress used unmodified, low bits included.

Structure
REQ-032 Package fetch_pkg SHALL hold enum fetchState_t, localparam PC_STEP=32'd4 and default RESET_PC value.
REQ-033 No sub-module; the PC register, FSM and instrBuf are implemented inline in one module.

Verification
REQ-034 Reset release, imemReqReady=1, responses 1 cycle later, fetchReady=1 -> imemReqAddr sequence 0x0,0x4,0x8; fetchPc matches.
REQ-035 takeBranch=1, branchAddress=0x100 while in WAIT, response after 2 cycles -> response dropped, next imemReqAddr=0x100, no fetchValid for old PC.
REQ-036 HOLD with fetchReady=0 for 5 cycles -> fetchValid=1, fetchInstr/fetchPc stable; then fetchReady=1 -> next imemReqAddr=fetchPc+4.
REQ-037 pc=0xFFFF_FFFC fetched and accepted -> next imemReqAddr=0x0000_0000.
REQ-038 takeBranch with branchAddress=0x102, FETCH_MISALIGN_TRAP_EN defined -> misalignTrap pulses 1 cycle, PC sequence unchanged; undefined -> imemReqAddr=0x102.
REQ-039 reset asserted during HOLD -> fetchValid=0 immediately; after release first imemReqAddr=RESET_PC.
